uart_tx_arb: RTL and testbench

Arbiter and sequencer that shares one `uart_tx` transmitter between `N_REQ` byte-producing requesters. It accepts one byte at a time over a per-requester valid/ready handshake, issues a single-cycle `tx_start`/`tx_data` to the transmitter, and tracks the transmitter's `tx_busy` through one full frame before granting again. It sits between the system's byte sources (console, debug, status) and the UART transmitter.

---
 rtl/uart_tx_arb_pkg.sv | 10 +
 rtl/uart_tx_arb_rr_pick.sv | 46 ++++
 rtl/uart_tx_arb.sv | 77 +++++++
 tb/tb_uart_tx_arb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: FSM state encoding and defaults shared by the UART transmit arbiter.
package uart_tx_arb_pkg;
    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        LAUNCH    = 4'b0010,
        WAIT_BUSY = 4'b0100,
        WAIT_DONE = 4'b1000
    } arb_state_t;
    localparam int BUSY_TIMEOUT_DEF = 4;
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: first-valid requester search from a start pointer; the pointer rotates only
// when UART_TX_ARB_RR_EN is defined, otherwise the search is fixed-priority from 0.
module rr_pick #(
    parameter int N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] ptr;
    logic [IW-1:0] j;
    int s;
`ifdef UART_TX_ARB_RR_EN
    always_ff @(posedge clk_i)
        if (rst_i)
            ptr <= '0;
        else if (advance_i)
            ptr <= (last_i == IW'(N-1)) ? '0 : last_i + 1'b1;
`else
    logic unused_ok;
    assign ptr = '0;
    assign unused_ok = ^{clk_i, rst_i, advance_i, last_i};
`endif
    // Walk offsets from farthest to nearest so the nearest valid index is left standing.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        s = 0;
        j = '0;
        for (int k = N-1; k >= 0; k--) begin
            s = int'(ptr) + k;
            j = IW'(s >= N ? s - N : s);
            if (req_i[j]) begin
                idx_o = j;
                any_o = 1'b1;
            end
        end
    end
    assign gnt_o = any_o ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART transmitter among N_REQ byte sources, one frame at a time.
// Round-robin selection with UART_TX_ARB_RR_EN defined, fixed priority otherwise.
module uart_tx_arb import uart_tx_arb_pkg::*; #(
    parameter int N_REQ        = 4,
    parameter int DW           = 8,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*DW-1:0]      req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     tx_start_o,
    output logic [DW-1:0]            tx_data_o,
    input  logic                     tx_busy_i,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     active_o,
    output logic                     err_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    arb_state_t    state;
    logic [DW-1:0] data_q;
    logic [IW-1:0] gid_q;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0] idx;
    logic          any;
    logic          accept;
    logic          timeout;
    logic          done;

    rr_pick #(.N(N_REQ)) u_pick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_valid_i),
        .advance_i (timeout | done),
        .last_i    (gid_q),
        .gnt_o     (gnt),
        .idx_o     (idx),
        .any_o     (any)
    );

    assign accept  = (state == IDLE) && !tx_busy_i && any && !rst_i;
    // cnt holds cycles elapsed since the start pulse while waiting for busy.
    assign timeout = (state == WAIT_BUSY) && !tx_busy_i && (cnt >= CW'(BUSY_TIMEOUT - 1));
    assign done    = (state == WAIT_DONE) && !tx_busy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            data_q <= '0;
            gid_q  <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout;
            cnt   <= (state == WAIT_BUSY) ? cnt + 1'b1 : CW'(1);
            if (accept) begin
                data_q <= req_data_i[idx*DW +: DW];
                gid_q  <= idx;
            end
            state <= accept                             ? LAUNCH    :
                     (state == LAUNCH)                  ? WAIT_BUSY :
                     (state == WAIT_BUSY && tx_busy_i)  ? WAIT_DONE :
                     (timeout || done)                  ? IDLE      : state;
        end
    end

    assign req_ready_o = accept ? gnt : '0;
    assign tx_start_o  = (state == LAUNCH);
    assign active_o    = (state != IDLE);
    assign err_o       = err_q;
    assign tx_data_o   = data_q;
    assign grant_id_o  = gid_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench with a simple transmitter model driving tx_busy_i.
module tb_uart_tx_arb;
    localparam int N = 4, DW = 8, T = 4, FRAME = 5;
`ifdef UART_TX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    id;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0]    req_ready_o;
    logic            tx_start_o;
    logic [DW-1:0]   tx_data_o;
    logic            tx_busy_i;
    logic [1:0]      grant_id_o;
    logic            active_o;
    logic            err_o;

    exp_t sb[$];
    int checks = 0, errors = 0, n_start = 0, busy_cnt = 0, base = 0, cyc = 0;
    bit no_busy = 1'b0, force_busy = 1'b0;

    always #5 clk_i = ~clk_i;

    uart_tx_arb dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .tx_busy_i   (tx_busy_i),
        .grant_id_o  (grant_id_o),
        .active_o    (active_o),
        .err_o       (err_o)
    );

    // Transmitter model: busy from the cycle after the start pulse for FRAME cycles.
    always @(posedge clk_i)
        busy_cnt <= rst_i ? 0 : (tx_start_o && !no_busy) ? FRAME : (busy_cnt > 0 ? busy_cnt - 1 : 0);
    assign tx_busy_i = (busy_cnt != 0) || force_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        chk("ready_onehot", 32'($onehot0(req_ready_o)), 1);
        if (|req_ready_o) chk("ready_only_idle", active_o, 0);
        if (tx_start_o) begin
            n_start++;
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
                e = sb.pop_front();
                chk("start_data", tx_data_o, e.d);
                chk("start_id", grant_id_o, e.id);
            end
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic push(input int r);
        exp_t e;
        e.d  = req_data_i[r*DW +: DW];
        e.id = 2'(r);
        sb.push_back(e);
    endtask

    task automatic wait_starts(input int target);
        for (int i = 0; i < 200 && n_start < target; i++) tick();
        chk("start_count", n_start, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && active_o; i++) tick();
        chk("back_idle", active_o, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, req_ready_o, 0);
        chk({tag, "_start"}, tx_start_o, 0);
        chk({tag, "_data"}, tx_data_o, 0);
        chk({tag, "_gid"}, grant_id_o, 0);
        chk({tag, "_active"}, active_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        do_reset();
        chk_zero("reset");

        // Single byte from requester 2
        req_data_i[2*DW +: DW] = 8'hA5;
        req_valid_i = 4'b0100;
        #1;
        chk("single_ready", req_ready_o, 4'b0100);
        push(2);
        wait_starts(1);
        req_valid_i = '0;
        for (int i = 0; i < 20 && !tx_busy_i; i++) tick();
        for (int i = 0; i < 20 && tx_busy_i; i++) tick();
        chk("active_at_busy_fall", active_o, 1);
        tick();
        chk("idle_after_fall", active_o, 0);

        // Contention, all four requesters
        do_reset();
        req_data_i = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) push(RR ? k % 4 : 0);
        base = n_start;
        req_valid_i = 4'b1111;
        wait_starts(base + 5);
        req_valid_i = '0;
        wait_idle();

        // Pointer wrap: serve 2 first so the pointer sits at 3, then 1 and 3 compete
        do_reset();
        req_data_i = {8'h23, 8'h22, 8'h21, 8'h20};
        push(2);
        base = n_start;
        req_valid_i = 4'b0100;
        wait_starts(base + 1);
        req_valid_i = 4'b1010;
        push(RR ? 3 : 1);
        push(1);
        push(RR ? 3 : 1);
        wait_starts(base + 4);
        req_valid_i = '0;
        wait_idle();

        // Busy timeout
        do_reset();
        no_busy = 1'b1;
        req_data_i = {8'h43, 8'h42, 8'h41, 8'h40};
        push(0);
        push(RR ? 1 : 0);
        base = n_start;
        req_valid_i = 4'b0011;
        wait_starts(base + 1);
        cyc = 0;
        for (int i = 0; i < T + 5 && !err_o; i++) begin
            tick();
            cyc++;
        end
        chk("err_delay", cyc, T);
        chk("err_in_idle", active_o, 0);
        tick();
        chk("err_one_cycle", err_o, 0);
        wait_starts(base + 2);
        req_valid_i = '0;
        wait_idle();
        no_busy = 1'b0;

        // Transmitter busy in IDLE, then reset mid-frame
        do_reset();
        req_data_i = {8'h33, 8'h32, 8'h31, 8'h30};
        force_busy = 1'b1;
        req_valid_i = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_no_ready", req_ready_o, 0);
            chk("busy_no_grant", active_o, 0);
        end
        push(1);
        push(3);
        base = n_start;
        force_busy = 1'b0;
        wait_starts(base + 1);
        req_valid_i = 4'b1000;
        wait_starts(base + 2);
        for (int i = 0; i < 20 && !tx_busy_i; i++) tick();
        tick();
        chk("mid_frame", active_o & tx_busy_i, 1);
        rst_i = 1'b1;
        req_valid_i = 4'b1001;
        tick();
        chk_zero("midrst");
        rst_i = 1'b0;
        push(0);
        wait_starts(base + 3);
        req_valid_i = '0;
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
